constant_splitter: RTL and testbench

- Narrowing counterpart of the immediate sign extender. Takes a 32-bit constant plus destination register and emits the minimal immediate-load word sequence.
- Emits a single LOADLIT word when the constant is the sign-extension of its low 16 bits; otherwise emits an LCH (high half) word followed by an LCL (low half) word.
- Sits in the instruction-generation / constant-materialisation path, upstream of the decoder whose extender widens the same 16-bit immediates.

---
 rtl/constant_splitter_pkg.sv | 27 ++
 rtl/constant_splitter_imm_fit_check.sv | 25 ++
 rtl/constant_splitter.sv | 163 ++++++++++++++++
 tb/tb_constant_splitter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/constant_splitter_pkg.sv
// -----------------------------------------------------------------------------
// constant_splitter_pkg
// Shared definitions for the constant-materialisation path:
//   - opcodes of the immediate-load words (LOADLIT / LCH / LCL)
//   - state encoding of the splitter FSM
//   - default widths of the constant, immediate field and register index
// -----------------------------------------------------------------------------
package constant_splitter_pkg;

  localparam int CS_IMM_WIDTH  = 16;
  localparam int CS_DATA_WIDTH = 2 * CS_IMM_WIDTH;
  localparam int CS_REG_WIDTH  = 5;

  typedef enum logic [1:0] {
    OP_LOADLIT = 2'b00,  // rd <= sign_extend(imm)
    OP_LCH     = 2'b01,  // rd[31:16] <= imm
    OP_LCL     = 2'b10   // rd[15:0]  <= imm
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_EMIT_ONE = 2'b01,
    ST_EMIT_HI  = 2'b10,
    ST_EMIT_LO  = 2'b11
  } state_e;

endpackage : constant_splitter_pkg

// File: rtl/constant_splitter_imm_fit_check.sv
// -----------------------------------------------------------------------------
// imm_fit_check
// Combinational test of whether a VALUE_WIDTH-bit value is the sign extension
// of its low FIELD_WIDTH bits, i.e. whether it can be carried in a signed
// FIELD_WIDTH-bit immediate. Used with FIELD_WIDTH=16 for LOADLIT and can be
// reused with FIELD_WIDTH=12 for the jump range.
// Ports:
//   value_i  in  VALUE_WIDTH  value under test
//   fits_o   out 1            1 when all bits above the field equal its MSB
// -----------------------------------------------------------------------------
module imm_fit_check #(
  parameter int VALUE_WIDTH = 32,
  parameter int FIELD_WIDTH = 16
) (
  input  logic [VALUE_WIDTH-1:0] value_i,
  output logic                   fits_o
);

  localparam int UPPER_WIDTH = VALUE_WIDTH - FIELD_WIDTH;

  // Every bit above the field must replicate the field's sign bit.
  assign fits_o = (value_i[VALUE_WIDTH-1:FIELD_WIDTH] ==
                   {UPPER_WIDTH{value_i[FIELD_WIDTH-1]}});

endmodule : imm_fit_check

// File: rtl/constant_splitter.sv
// -----------------------------------------------------------------------------
// constant_splitter
// Turns a DATA_WIDTH-bit constant plus destination register into the shortest
// immediate-load word sequence:
//   - one LOADLIT word when the constant sign-extends from its low half;
//   - otherwise an LCH word (high half) followed by an LCL word (low half).
// All outputs are registered; the first word is valid one cycle after accept.
// Ports:
//   Clock     in  1           rising-edge clock
//   Reset     in  1           synchronous, active-low reset
//   InValid   in  1           constant request valid
//   InReady   out 1           request accepted when high (IDLE only)
//   ConstIn   in  DATA_WIDTH  constant to materialise
//   RdIn      in  REG_WIDTH   destination register
//   OutValid  out 1           output word valid
//   OutReady  in  1           consumer accepts the current word
//   OutOp     out 2           word opcode (op_e)
//   OutRd     out REG_WIDTH   destination register of the word
//   OutImm    out IMM_WIDTH   immediate field of the word
//   OutLast   out 1           final word of the current constant
// -----------------------------------------------------------------------------
module constant_splitter
  import constant_splitter_pkg::*;
#(
  parameter int DATA_WIDTH = CS_DATA_WIDTH,
  parameter int IMM_WIDTH  = CS_IMM_WIDTH,
  parameter int REG_WIDTH  = CS_REG_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [DATA_WIDTH-1:0] ConstIn,
  input  logic [REG_WIDTH-1:0]  RdIn,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [1:0]            OutOp,
  output logic [REG_WIDTH-1:0]  OutRd,
  output logic [IMM_WIDTH-1:0]  OutImm,
  output logic                  OutLast
);

  state_e                 state_q,     state_d;
  logic                   in_ready_q,  in_ready_d;
  logic [IMM_WIDTH-1:0]   lo_q,        lo_d;   // low half kept for the LCL word
  logic [REG_WIDTH-1:0]   rd_q,        rd_d;
  logic                   out_valid_q, out_valid_d;
  op_e                    out_op_q,    out_op_d;
  logic [REG_WIDTH-1:0]   out_rd_q,    out_rd_d;
  logic [IMM_WIDTH-1:0]   out_imm_q,   out_imm_d;
  logic                   out_last_q,  out_last_d;

  logic                   fits;
  logic                   accept;

  imm_fit_check #(
    .VALUE_WIDTH (DATA_WIDTH),
    .FIELD_WIDTH (IMM_WIDTH)
  ) u_fit (
    .value_i (ConstIn),
    .fits_o  (fits)
  );

  // InReady is registered, so it is low for the first cycle after reset
  // release even though the FSM already sits in IDLE.
  assign accept = (state_q == ST_IDLE) && in_ready_q && InValid;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    lo_d        = lo_q;
    rd_d        = rd_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_rd_d    = out_rd_q;
    out_imm_d   = out_imm_q;
    out_last_d  = out_last_q;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          // Capture the request and load the first word on the same edge.
          lo_d        = ConstIn[IMM_WIDTH-1:0];
          rd_d        = RdIn;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          out_rd_d    = RdIn;
          if (fits) begin
            state_d    = ST_EMIT_ONE;
            out_op_d   = OP_LOADLIT;
            out_imm_d  = ConstIn[IMM_WIDTH-1:0];
            out_last_d = 1'b1;
          end else begin
            state_d    = ST_EMIT_HI;
            out_op_d   = OP_LCH;
            out_imm_d  = ConstIn[DATA_WIDTH-1:IMM_WIDTH];
            out_last_d = 1'b0;
          end
        end
      end

      ST_EMIT_HI: begin
        if (OutReady) begin
          state_d    = ST_EMIT_LO;
          out_op_d   = OP_LCL;
          out_rd_d   = rd_q;
          out_imm_d  = lo_q;
          out_last_d = 1'b1;
        end
      end

      ST_EMIT_ONE, ST_EMIT_LO: begin
        if (OutReady) begin
          // Final word consumed; ready for the next request next cycle.
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      lo_q        <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= OP_LOADLIT;
      out_rd_q    <= '0;
      out_imm_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      lo_q        <= lo_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_rd_q    <= out_rd_d;
      out_imm_q   <= out_imm_d;
      out_last_q  <= out_last_d;
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign OutOp    = out_op_q;
  assign OutRd    = out_rd_q;
  assign OutImm   = out_imm_q;
  assign OutLast  = out_last_q;

endmodule : constant_splitter

// File: tb/tb_constant_splitter.sv
// -----------------------------------------------------------------------------
// tb_constant_splitter
// Directed self-checking bench for constant_splitter. Inputs change 1 ns after
// the rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_constant_splitter;

  logic        Clock;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [31:0] ConstIn;
  logic [4:0]  RdIn;
  logic        OutValid;
  logic        OutReady;
  logic [1:0]  OutOp;
  logic [4:0]  OutRd;
  logic [15:0] OutImm;
  logic        OutLast;

  localparam logic [1:0] LOADLIT = 2'b00;
  localparam logic [1:0] LCH     = 2'b01;
  localparam logic [1:0] LCL     = 2'b10;

  int n_vec;
  int n_err;

  constant_splitter dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .ConstIn  (ConstIn),
    .RdIn     (RdIn),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutOp    (OutOp),
    .OutRd    (OutRd),
    .OutImm   (OutImm),
    .OutLast  (OutLast)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset    = 1'b0;
    InValid  = 1'b0;
    ConstIn  = '0;
    RdIn     = '0;
    OutReady = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({InReady, OutValid, OutOp, OutRd, OutImm, OutLast} !== 26'd0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b vld=%b op=%h rd=%h imm=%h last=%b expected all zero",
               InReady, OutValid, OutOp, OutRd, OutImm, OutLast);
    end
    Reset = 1'b1;
    tick();
    n_vec++;
    if (InReady !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b expected 1", InReady);
    end
  endtask

  task automatic test_single_fit();
    OutReady = 1'b1;
    InValid  = 1'b1;
    ConstIn  = 32'h0000_1234;
    RdIn     = 5'd3;
    tick();
    InValid = 1'b0;
    n_vec++;
    if ({OutValid, OutOp, OutImm, OutRd, OutLast, InReady} !== {1'b1, LOADLIT, 16'h1234, 5'd3, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL single_fit_word: got vld=%b op=%h imm=%h rd=%0d last=%b rdy=%b expected 1 0 1234 3 1 0",
               OutValid, OutOp, OutImm, OutRd, OutLast, InReady);
    end
    tick();
    n_vec++;
    if ({OutValid, InReady} !== 2'b01) begin
      n_err++;
      $display("FAIL single_fit_done: got vld=%b rdy=%b expected vld=0 rdy=1", OutValid, InReady);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] consts [6];
    logic        fit    [6];
    consts = '{32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_0000,
               32'h0000_8000, 32'hFFFF_7FFF, 32'h8000_0000};
    fit    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    OutReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] c;
      c = consts[i];
      n_vec++;
      if (InReady !== 1'b1) begin
        n_err++;
        $display("FAIL bound_ready[%0d]: got %b expected 1", i, InReady);
      end
      InValid = 1'b1;
      ConstIn = c;
      RdIn    = 5'(i + 10);
      tick();
      InValid = 1'b0;
      if (fit[i]) begin
        n_vec++;
        if ({OutValid, OutOp, OutImm, OutRd, OutLast} !== {1'b1, LOADLIT, c[15:0], 5'(i + 10), 1'b1}) begin
          n_err++;
          $display("FAIL bound_loadlit[%0d]: got vld=%b op=%h imm=%h rd=%0d last=%b expected 1 0 %h %0d 1",
                   i, OutValid, OutOp, OutImm, OutRd, OutLast, c[15:0], i + 10);
        end
      end else begin
        n_vec++;
        if ({OutValid, OutOp, OutImm, OutRd, OutLast} !== {1'b1, LCH, c[31:16], 5'(i + 10), 1'b0}) begin
          n_err++;
          $display("FAIL bound_lch[%0d]: got vld=%b op=%h imm=%h rd=%0d last=%b expected 1 1 %h %0d 0",
                   i, OutValid, OutOp, OutImm, OutRd, OutLast, c[31:16], i + 10);
        end
        tick();
        n_vec++;
        if ({OutValid, OutOp, OutImm, OutRd, OutLast} !== {1'b1, LCL, c[15:0], 5'(i + 10), 1'b1}) begin
          n_err++;
          $display("FAIL bound_lcl[%0d]: got vld=%b op=%h imm=%h rd=%0d last=%b expected 1 2 %h %0d 1",
                   i, OutValid, OutOp, OutImm, OutRd, OutLast, c[15:0], i + 10);
        end
      end
      tick();
      n_vec++;
      if (OutValid !== 1'b0) begin
        n_err++;
        $display("FAIL bound_end[%0d]: got vld=%b expected 0", i, OutValid);
      end
    end
  endtask

  task automatic test_backpressure();
    OutReady = 1'b0;
    InValid  = 1'b1;
    ConstIn  = 32'h1234_5678;
    RdIn     = 5'd7;
    tick();
    InValid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({OutValid, OutOp, OutImm, OutRd, OutLast} !== {1'b1, LCH, 16'h1234, 5'd7, 1'b0}) begin
        n_err++;
        $display("FAIL bp_lch_hold[%0d]: got vld=%b op=%h imm=%h rd=%0d last=%b expected 1 1 1234 7 0",
                 k, OutValid, OutOp, OutImm, OutRd, OutLast);
      end
      if (k < 3) tick();
    end
    OutReady = 1'b1;
    tick();
    n_vec++;
    if ({OutValid, OutOp, OutImm, OutRd, OutLast} !== {1'b1, LCL, 16'h5678, 5'd7, 1'b1}) begin
      n_err++;
      $display("FAIL bp_lcl: got vld=%b op=%h imm=%h rd=%0d last=%b expected 1 2 5678 7 1",
               OutValid, OutOp, OutImm, OutRd, OutLast);
    end
    tick();
    n_vec++;
    if ({OutValid, InReady} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_done: got vld=%b rdy=%b expected vld=0 rdy=1", OutValid, InReady);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] reqs [3];
    logic [4:0]  rds  [3];
    logic [1:0]  eop  [4];
    logic [15:0] eimm [4];
    logic [4:0]  erd  [4];
    logic        elast[4];
    int          r;
    int          w;
    logic        acc;
    reqs  = '{32'h0000_0001, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    rds   = '{5'd1, 5'd2, 5'd31};
    eop   = '{LOADLIT, LCH, LCL, LOADLIT};
    eimm  = '{16'h0001, 16'hDEAD, 16'hBEEF, 16'hFFFF};
    erd   = '{5'd1, 5'd2, 5'd2, 5'd31};
    elast = '{1'b1, 1'b0, 1'b1, 1'b1};
    r = 0;
    w = 0;
    OutReady = 1'b1;
    InValid  = 1'b1;
    ConstIn  = reqs[0];
    RdIn     = rds[0];
    for (int c = 0; c < 20 && w < 4; c++) begin
      acc = InReady && InValid;
      tick();
      if (acc) begin
        r++;
        if (r < 3) begin
          ConstIn = reqs[r];
          RdIn    = rds[r];
        end else begin
          InValid = 1'b0;
        end
      end
      if (OutValid === 1'b1) begin
        n_vec++;
        if ({OutOp, OutImm, OutRd, OutLast} !== {eop[w], eimm[w], erd[w], elast[w]}) begin
          n_err++;
          $display("FAIL b2b_word[%0d]: got op=%h imm=%h rd=%0d last=%b expected op=%h imm=%h rd=%0d last=%b",
                   w, OutOp, OutImm, OutRd, OutLast, eop[w], eimm[w], erd[w], elast[w]);
        end
        w++;
      end
    end
    InValid = 1'b0;
    n_vec++;
    if (w != 4 || r != 3) begin
      n_err++;
      $display("FAIL b2b_count: got words=%0d accepts=%0d expected words=4 accepts=3", w, r);
    end
    tick();
    n_vec++;
    if ({OutValid, InReady} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_idle: got vld=%b rdy=%b expected vld=0 rdy=1", OutValid, InReady);
    end
  endtask

  task automatic test_reset_mid();
    OutReady = 1'b0;
    InValid  = 1'b1;
    ConstIn  = 32'hCAFE_F00D;
    RdIn     = 5'd9;
    tick();
    InValid = 1'b0;
    n_vec++;
    if ({OutValid, OutOp, OutImm, OutRd} !== {1'b1, LCH, 16'hCAFE, 5'd9}) begin
      n_err++;
      $display("FAIL rst_mid_lch: got vld=%b op=%h imm=%h rd=%0d expected 1 1 cafe 9",
               OutValid, OutOp, OutImm, OutRd);
    end
    Reset = 1'b0;
    tick();
    Reset    = 1'b1;
    OutReady = 1'b1;
    n_vec++;
    if ({OutValid, OutLast, InReady} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_mid_cleared: got vld=%b last=%b rdy=%b expected 0 0 0", OutValid, OutLast, InReady);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if ({OutValid, InReady} !== 2'b01) begin
        n_err++;
        $display("FAIL rst_mid_no_lcl[%0d]: got vld=%b rdy=%b imm=%h expected vld=0 rdy=1",
                 k, OutValid, InReady, OutImm);
      end
    end
  endtask

  task automatic test_ignore_while_busy();
    OutReady = 1'b0;
    InValid  = 1'b1;
    ConstIn  = 32'hABCD_0001;
    RdIn     = 5'd4;
    tick();
    ConstIn = 32'h0000_0055;
    RdIn    = 5'd5;
    n_vec++;
    if (InReady !== 1'b0) begin
      n_err++;
      $display("FAIL ign_busy_ready: got %b expected 0", InReady);
    end
    tick();
    InValid  = 1'b0;
    OutReady = 1'b1;
    n_vec++;
    if ({OutValid, OutOp, OutImm, OutRd} !== {1'b1, LCH, 16'hABCD, 5'd4}) begin
      n_err++;
      $display("FAIL ign_lch: got vld=%b op=%h imm=%h rd=%0d expected 1 1 abcd 4",
               OutValid, OutOp, OutImm, OutRd);
    end
    tick();
    n_vec++;
    if ({OutValid, OutOp, OutImm, OutRd, OutLast} !== {1'b1, LCL, 16'h0001, 5'd4, 1'b1}) begin
      n_err++;
      $display("FAIL ign_lcl: got vld=%b op=%h imm=%h rd=%0d last=%b expected 1 2 0001 4 1",
               OutValid, OutOp, OutImm, OutRd, OutLast);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if (OutValid !== 1'b0) begin
        n_err++;
        $display("FAIL ign_no_extra[%0d]: got vld=%b op=%h imm=%h expected vld=0", k, OutValid, OutOp, OutImm);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_fit();
    test_boundaries();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_ignore_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_constant_splitter
